// File: rtl/alu_arith_pkg.sv
// rtl/alu_arith_pkg.sv - shared types and op-decode helpers for the sequential arithmetic unit
//
// Purpose: operation and FSM state enums plus small decode helpers used by
// alu_arith_seq and alu_iter_core.
// Ports: none (package).

package alu_arith_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_DIV  = 3'b010,
        OP_MUL  = 3'b011,
        OP_MOD  = 3'b100,
        OP_MULH = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    // Raw 3-bit op field to op_e; the two unused codes alias to ADD.
    function automatic op_e decode_op(input logic [2:0] code);
        case (code)
            3'b001:  return OP_SUB;
            3'b010:  return OP_DIV;
            3'b011:  return OP_MUL;
            3'b100:  return OP_MOD;
            3'b101:  return OP_MULH;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic is_iterative(input op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_MOD);
    endfunction

    function automatic logic is_divide(input op_e o);
        return (o == OP_DIV) || (o == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_arith_seq_if.sv
// rtl/alu_arith_seq_if.sv - operand/result handshake bundle for alu_arith_seq
//
// Purpose: groups the input handshake (in_valid/in_ready, a, b, op) and the
// output handshake (out_valid/out_ready, result and status flags).
// Modports: master = requester/consumer side, slave = the arithmetic unit.

interface alu_arith_seq_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
    logic         dz;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, neg, dz
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, neg, dz
    );
endinterface

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - one-bit-per-cycle shift-add multiplier / restoring divider
//
// Purpose: iterative datapath owned by the alu_arith_seq FSM.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture a, b, op and set the counter to N
//   step            perform one iteration (ignored when counter is 0)
//   op              operation being loaded (selects mul or div datapath)
//   a, b            operands (multiplicand/multiplier, dividend/divisor)
//   last            counter == 1: the current step is the final one
//   prod_next       2N-bit product after the current step
//   quot_next       quotient after the current step
//   rem_next        remainder after the current step

module alu_iter_core
    import alu_arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  op_e            op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           last,
    output logic [2*N-1:0] prod_next,
    output logic [N-1:0]   quot_next,
    output logic [N-1:0]   rem_next
);
    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] p;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   rem;
    logic [N-1:0]   dq;        // dividend shifts out at the top, quotient bits enter at the bottom
    logic [N-1:0]   divisor;
    logic [CW-1:0]  cnt;
    logic           div_sel;

    logic [N:0]     r_sh;
    logic           r_ge;

    assign prod_next = mplier[0] ? (p + mcand) : p;

    assign r_sh      = {rem, dq[N-1]};
    assign r_ge      = (r_sh >= {1'b0, divisor});
    // When r_ge holds the true difference is below divisor, so N bits suffice.
    assign rem_next  = r_ge ? (r_sh[N-1:0] - divisor) : r_sh[N-1:0];
    assign quot_next = {dq[N-2:0], r_ge};

    assign last      = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            dq      <= '0;
            divisor <= '0;
            cnt     <= '0;
            div_sel <= 1'b0;
        end else if (load) begin
            p       <= '0;
            mcand   <= {{N{1'b0}}, a};
            mplier  <= b;
            rem     <= '0;
            dq      <= a;
            divisor <= b;
            cnt     <= CW'(N);
            div_sel <= is_divide(op);
        end else if (step && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
            if (div_sel) begin
                rem <= rem_next;
                dq  <= quot_next;
            end else begin
                p      <= prod_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_arith_seq.sv
// rtl/alu_arith_seq.sv - sequential arithmetic unit: 1-cycle ADD/SUB, N-cycle MUL/MULH/DIV/MOD
//
// Purpose: accepts one operation in IDLE, computes it (directly or through
// alu_iter_core), holds result and registered flags in DONE until taken.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   alu_arith_seq_if.slave: in_valid/in_ready, a, b, op,
//         out_valid/out_ready, result, cout, ovf, zero, neg, dz

module alu_arith_seq
    import alu_arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_arith_seq_if.slave   bus
);
    state_e       state_q, state_d;
    op_e          op_q, op_d, op_in;
    logic [N-1:0] result_q, result_d;
    logic         cout_q, cout_d;
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;
    logic         dz_q, dz_d;
    logic         upd;

    logic           core_load;
    logic           core_step;
    logic           core_last;
    logic [2*N-1:0] prod_next;
    logic [N-1:0]   quot_next;
    logic [N-1:0]   rem_next;

    logic [N:0]     sum;
    logic [N:0]     diff;

    assign op_in = decode_op(bus.op);
    assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff  = {1'b0, bus.a} - {1'b0, bus.b};   // diff[N] is the borrow

    alu_iter_core #(.N(N)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .op        (op_in),
        .a         (bus.a),
        .b         (bus.b),
        .last      (core_last),
        .prod_next (prod_next),
        .quot_next (quot_next),
        .rem_next  (rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        upd       = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d = op_in;
                    if (is_iterative(op_in) && !(is_divide(op_in) && (bus.b == '0))) begin
                        core_load = 1'b1;
                        state_d   = S_BUSY;
                    end else begin
                        upd     = 1'b1;
                        state_d = S_DONE;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                        dz_d    = 1'b0;
                        case (op_in)
                            OP_ADD: begin
                                result_d = sum[N-1:0];
                                cout_d   = sum[N];
                                ovf_d    = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
                            end
                            OP_SUB: begin
                                result_d = diff[N-1:0];
                                cout_d   = diff[N];
                                ovf_d    = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
                            end
                            default: begin
                                // Only DIV/MOD by zero reach here.
                                dz_d     = 1'b1;
                                result_d = (op_in == OP_DIV) ? {N{1'b1}} : bus.a;
                            end
                        endcase
                    end
                end
            end
            S_BUSY: begin
                core_step = 1'b1;
                if (core_last) begin
                    upd     = 1'b1;
                    state_d = S_DONE;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    case (op_q)
                        OP_MUL: begin
                            result_d = prod_next[N-1:0];
                            cout_d   = |prod_next[2*N-1:N];
                        end
                        OP_MULH: begin
                            result_d = prod_next[2*N-1:N];
                            cout_d   = |prod_next[2*N-1:N];
                        end
                        OP_DIV:  result_d = quot_next;
                        default: result_d = rem_next;
                    endcase
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // zero/neg only change when a new result is registered, so the
        // cleared-by-reset values are not overwritten from result == 0.
        zero_d = upd ? (result_d == '0) : zero_q;
        neg_d  = upd ? result_d[N-1]    : neg_q;
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.dz        = dz_q;

endmodule
